// File: rtl/mul_serial.sv
`default_nettype none
// ============================================================================
// Module      : mul_serial
// Description : Bit-serial MSB-first GF(2^163) multiplier,
//               f(x) = x^163 + x^7 + x^6 + x^3 + 1. 163 RUN cycles per product.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_serial (
    input  logic         CLK,
    input  logic         RST,
    input  logic         MUL_START,
    input  logic [162:0] MUL_A,
    input  logic [162:0] MUL_B,
    output logic [162:0] MUL_R,
    output logic         MUL_BUSY,
    output logic         MUL_DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // x^163 folds back onto x^7 + x^6 + x^3 + 1
    localparam logic [162:0] c_RED_POLY = 163'hC9;
    localparam logic [7:0]   c_LAST_BIT = 8'd162;

    state_t       r_state_q, w_state_d;
    logic [162:0] r_a_q, w_a_d;
    logic [162:0] r_b_q, w_b_d;
    logic [162:0] r_c_q, w_c_d;
    logic [162:0] r_r_q, w_r_d;
    logic [7:0]   r_cnt_q, w_cnt_d;
    logic [162:0] w_c_shift;
    logic [162:0] w_c_step;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q <= S_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_c_q     <= '0;
            r_r_q     <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_c_q     <= w_c_d;
            r_r_q     <= w_r_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_c_d     = r_c_q;
        w_r_d     = r_r_q;
        w_cnt_d   = r_cnt_q;

        w_c_shift = {r_c_q[161:0], 1'b0} ^ (r_c_q[162] ? c_RED_POLY : '0);
        w_c_step  = w_c_shift ^ (r_b_q[r_cnt_q] ? r_a_q : '0);

        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (MUL_START) begin
                    w_state_d = S_RUN;
                    w_a_d     = MUL_A;
                    w_b_d     = MUL_B;
                    w_c_d     = '0;
                    w_cnt_d   = c_LAST_BIT;
                end else begin
                    w_state_d = S_IDLE;
                end
            end
            S_RUN: begin
                w_c_d = w_c_step;
                if (r_cnt_q == 8'd0) begin
                    // Final step lands straight in the result register
                    w_r_d     = w_c_step;
                    w_state_d = S_DONE;
                end else begin
                    w_cnt_d = r_cnt_q - 8'd1;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    assign MUL_R    = r_r_q;
    assign MUL_BUSY = (r_state_q == S_RUN);
    assign MUL_DONE = (r_state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mul_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_serial
// Description : Self-checking bench for mul_serial against a polynomial-product
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_serial;

    logic         CLK;
    logic         RST;
    logic         MUL_START;
    logic [162:0] MUL_A;
    logic [162:0] MUL_B;
    logic [162:0] MUL_R;
    logic         MUL_BUSY;
    logic         MUL_DONE;

    int n_cmp = 0;
    int n_err = 0;
    logic [162:0] last_r;

    mul_serial dut (
        .CLK       (CLK),
        .RST       (RST),
        .MUL_START (MUL_START),
        .MUL_A     (MUL_A),
        .MUL_B     (MUL_B),
        .MUL_R     (MUL_R),
        .MUL_BUSY  (MUL_BUSY),
        .MUL_DONE  (MUL_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Full 325-bit polynomial product, then long division by f(x)
    function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
        logic [324:0] p;
        logic [324:0] f;
        p = '0;
        for (int i = 0; i < 163; i++)
            if (b[i]) p = p ^ ({162'b0, a} << i);
        f = '0;
        f[163] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
        for (int i = 324; i >= 163; i--)
            if (p[i]) p = p ^ (f << (i - 163));
        return p[162:0];
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[162:0];
    endfunction

    task automatic check(input string tag, input logic [162:0] obs, input logic [162:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated multiply; optional mid-run start pulse with other operands
    task automatic run_op(input logic [162:0] a, input logic [162:0] b, input int pulse_at);
        logic [162:0] exp;
        int busy_n;
        int k;
        int dones;
        exp = gf_mul(a, b);
        @(negedge CLK);
        MUL_START = 1'b1; MUL_A = a; MUL_B = b;
        @(negedge CLK);
        MUL_START = 1'b0; MUL_A = rand163(); MUL_B = rand163();
        check("r_held_in_run", MUL_R, last_r);
        busy_n = MUL_BUSY ? 1 : 0;
        dones = 0;
        for (k = 2; k <= 400; k++) begin
            if (k == pulse_at) begin
                MUL_START = 1'b1; MUL_A = ~a; MUL_B = ~b;
            end else begin
                MUL_START = 1'b0;
            end
            @(negedge CLK);
            if (MUL_DONE) begin
                dones++;
                break;
            end
            if (MUL_BUSY) busy_n++;
        end
        MUL_START = 1'b0;
        check("done_latency", 163'(k), 163'd164);
        check("busy_cycles", 163'(busy_n), 163'd163);
        check("result", MUL_R, exp);
        @(negedge CLK);
        if (MUL_DONE) dones++;
        check("done_single_pulse", 163'(dones), 163'd1);
        check("busy_after_done", {162'b0, MUL_BUSY}, 163'd0);
        check("result_held_idle", MUL_R, exp);
        last_r = exp;
    endtask

    initial begin
        logic [162:0] x162;
        logic [162:0] ones;
        logic [162:0] exp;
        logic [162:0] na, nb;
        int k;
        int seen;

        x162 = '0; x162[162] = 1'b1;
        ones = '1;
        last_r = '0;
        RST = 1'b1; MUL_START = 1'b1; MUL_A = '1; MUL_B = '1;

        // Reset with start asserted: reset wins
        repeat (3) @(negedge CLK);
        check("rst_r", MUL_R, 163'd0);
        check("rst_busy", {162'b0, MUL_BUSY}, 163'd0);
        check("rst_done", {162'b0, MUL_DONE}, 163'd0);
        RST = 1'b0; MUL_START = 1'b0;

        run_op(163'd1, 163'd1, 0);
        run_op(x162, 163'd2, 0);
        check("reduction_c9", last_r, 163'hC9);
        run_op(ones, 163'd0, 0);
        run_op(163'd4, 163'd8, 0);
        check("x2_times_x3", last_r, 163'h20);

        // Start pulsed mid-run with different operands must be ignored
        na = rand163(); nb = rand163();
        run_op(na, nb, 50);

        // Reset at run cycle 80 aborts without a done pulse
        @(negedge CLK);
        MUL_START = 1'b1; MUL_A = rand163(); MUL_B = rand163();
        @(negedge CLK);
        MUL_START = 1'b0;
        seen = 0;
        repeat (79) begin
            @(negedge CLK);
            if (MUL_DONE) seen++;
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_busy", {162'b0, MUL_BUSY}, 163'd0);
        check("abort_r", MUL_R, 163'd0);
        check("abort_done", {162'b0, MUL_DONE}, 163'd0);
        repeat (200) begin
            @(negedge CLK);
            if (MUL_DONE) seen++;
        end
        check("abort_no_done", 163'(seen), 163'd0);
        last_r = '0;
        run_op(163'd3, 163'd3, 0);
        check("three_squared", last_r, 163'd5);

        // Back-to-back with start held: 3 directed then 200 random operand pairs
        @(negedge CLK);
        na = 163'd4; nb = 163'd8;
        MUL_START = 1'b1; MUL_A = na; MUL_B = nb;
        for (int i = 0; i < 203; i++) begin
            exp = gf_mul(na, nb);
            for (k = 1; k <= 400; k++) begin
                @(negedge CLK);
                if (MUL_DONE) break;
            end
            check("b2b_interval", 163'(k), 163'd164);
            check("b2b_result", MUL_R, exp);
            if (i == 0)      begin na = x162;      nb = x162;      end
            else if (i == 1) begin na = ones;      nb = ones;      end
            else             begin na = rand163(); nb = rand163(); end
            if (i == 202) MUL_START = 1'b0;
            MUL_A = na; MUL_B = nb;
        end
        @(negedge CLK);
        check("b2b_end_done", {162'b0, MUL_DONE}, 163'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
